// File: rtl/dsram_responder_if.sv
// Data SRAM bus between the EXE-stage requester and the data memory responder.
interface dsram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_we,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_we,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/dsram_responder.sv
// Data-side memory responder: byte-writable word RAM plus a small MMIO window
// (LED, free-running counter, scratch, status). Fixed one-cycle read latency,
// read-first on writes, rdata holds when idle.
module dsram_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE  = 32'hBFAF_0000
) (
  input  logic               clk,
  input  logic               reset,
  dsram_responder_if.slave   bus,
  output logic [15:0]        led,
  output logic               cnt_wrap
);

  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_COUNTER = 16'h0004;
  localparam logic [15:0] OFF_SCRATCH = 16'h0008;
  localparam logic [15:0] OFF_STATUS  = 16'h000C;

  logic                  mmio_sel;
  logic [15:0]           offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  ram_access;
  logic                  mmio_access;
  logic                  wr_any;

  assign mmio_sel    = (bus.data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign offset      = bus.data_sram_addr[15:0];
  assign word_idx    = bus.data_sram_addr[ADDR_WIDTH+1:2];
  assign ram_access  = bus.data_sram_en & ~mmio_sel;
  assign mmio_access = bus.data_sram_en & mmio_sel;
  assign wr_any      = |bus.data_sram_we;

  // Replace only the byte lanes selected by the write enables.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- RAM
  logic [31:0] ram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [2**ADDR_WIDTH];
      logic [7:0] rd_reg;

      // One byte lane: registered read-first port, write gated by its enable.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_reg <= '0;
        end else if (ram_access) begin
          rd_reg <= mem[word_idx];
          if (bus.data_sram_we[gi]) begin
            mem[word_idx] <= bus.data_sram_wdata[8*gi +: 8];
          end
        end
      end

      assign ram_rdata[8*gi +: 8] = rd_reg;
    end
  endgenerate

  // ---------------------------------------------------------------- MMIO
  logic [15:0] led_reg,      led_next;
  logic [31:0] counter_reg,  counter_next;
  logic [31:0] scratch_reg,  scratch_next;
  logic        cnt_wrap_reg, cnt_wrap_next;
  logic [31:0] mmio_rdata_reg, mmio_rd_val;
  logic        rsel_mmio_reg;
  logic        wrap_set;
  logic        status_clr;

  // Read mux over the pre-update register values.
  always_comb begin
    mmio_rd_val = '0;
    case (offset)
      OFF_LED:     mmio_rd_val = {16'h0000, led_reg};
      OFF_COUNTER: mmio_rd_val = counter_reg;
      OFF_SCRATCH: mmio_rd_val = scratch_reg;
      OFF_STATUS:  mmio_rd_val = {31'b0, cnt_wrap_reg};
      default:     mmio_rd_val = '0;
    endcase
  end

  // Next-state of MMIO registers; a counter write replaces the increment.
  always_comb begin
    led_next     = led_reg;
    scratch_next = scratch_reg;
    counter_next = counter_reg + 32'd1;
    wrap_set     = (counter_reg == 32'hFFFF_FFFF);
    status_clr   = 1'b0;
    if (mmio_access && wr_any) begin
      case (offset)
        OFF_LED: begin
          if (bus.data_sram_we[0]) led_next[7:0]  = bus.data_sram_wdata[7:0];
          if (bus.data_sram_we[1]) led_next[15:8] = bus.data_sram_wdata[15:8];
        end
        OFF_COUNTER: begin
          counter_next = byte_merge(counter_reg, bus.data_sram_wdata, bus.data_sram_we);
          wrap_set     = 1'b0;
        end
        OFF_SCRATCH: begin
          scratch_next = byte_merge(scratch_reg, bus.data_sram_wdata, bus.data_sram_we);
        end
        OFF_STATUS: begin
          status_clr = bus.data_sram_we[0] & bus.data_sram_wdata[0];
        end
        default: ;
      endcase
    end
    // Set beats clear when both land on the same edge.
    cnt_wrap_next = wrap_set | (cnt_wrap_reg & ~status_clr);
  end

  // MMIO register state and read-source tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_reg        <= '0;
      counter_reg    <= '0;
      scratch_reg    <= '0;
      cnt_wrap_reg   <= 1'b0;
      mmio_rdata_reg <= '0;
      rsel_mmio_reg  <= 1'b0;
    end else begin
      led_reg      <= led_next;
      counter_reg  <= counter_next;
      scratch_reg  <= scratch_next;
      cnt_wrap_reg <= cnt_wrap_next;
      if (mmio_access) mmio_rdata_reg <= mmio_rd_val;
      if (bus.data_sram_en) rsel_mmio_reg <= mmio_sel;
    end
  end

  assign bus.data_sram_rdata = rsel_mmio_reg ? mmio_rdata_reg : ram_rdata;
  assign led                 = led_reg;
  assign cnt_wrap            = cnt_wrap_reg;

endmodule
